litedram_axi_arb: RTL and testbench

Two-master to one-slave AXI4 arbiter in front of the LiteDRAM user port. It runs in the controller's `user_clk` domain and lets the CPU data path (m0) and a DMA/boot-loader path (m1) share the single `user_port0` AXI interface. Reads and writes are arbitrated independently. Each channel carries one burst at a time and locks until that burst's response completes.

---
 rtl/litedram_arb_pkg.sv | 9 +
 rtl/litedram_arb_rr.sv | 40 ++++
 rtl/litedram_axi_arb.sv | 275 +++++++++++++++++++++++++++
 tb/tb_litedram_axi_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/litedram_arb_pkg.sv
// Shared types and constants for the two-master LiteDRAM AXI4 arbiter.
package litedram_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rd_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/litedram_arb_rr.sv
// Two-request round-robin picker: registered grant, registered pointer that
// favours the master opposite to the one whose transaction just completed.
module litedram_arb_rr (
    input  logic       user_clk,
    input  logic       user_rst,
    input  logic [1:0] i_req,
    input  logic       i_load,
    input  logic       i_advance,
    output logic       o_grant
);

    logic r_grant;
    logic r_ptr;
    logic w_pick;

    // A lone requester wins; on a tie the pointer decides.
    always_comb begin
        case (i_req)
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = r_ptr;
            default: w_pick = 1'b0;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            if (i_load && (|i_req))
                r_grant <= w_pick;
            if (i_advance)
                r_ptr <= ~r_grant;
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/litedram_axi_arb.sv
// Two-master to one-slave AXI4 arbiter for the LiteDRAM user port; reads and
// writes are arbitrated independently and each channel locks for one burst.
module litedram_axi_arb
    import litedram_arb_pkg::*;
#(
    parameter int ID_WIDTH = 1,
    parameter int AW       = 27,
    parameter int DW       = 64
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    // master 0
    input  logic [ID_WIDTH-1:0]   i_m0_awid,
    input  logic [AW-1:0]         i_m0_awaddr,
    input  logic [7:0]            i_m0_awlen,
    input  logic [3:0]            i_m0_awsize,
    input  logic [1:0]            i_m0_awburst,
    input  logic                  i_m0_awvalid,
    output logic                  o_m0_awready,
    input  logic [DW-1:0]         i_m0_wdata,
    input  logic [DW/8-1:0]       i_m0_wstrb,
    input  logic                  i_m0_wlast,
    input  logic                  i_m0_wvalid,
    output logic                  o_m0_wready,
    output logic [ID_WIDTH-1:0]   o_m0_bid,
    output logic [1:0]            o_m0_bresp,
    output logic                  o_m0_bvalid,
    input  logic                  i_m0_bready,
    input  logic [ID_WIDTH-1:0]   i_m0_arid,
    input  logic [AW-1:0]         i_m0_araddr,
    input  logic [7:0]            i_m0_arlen,
    input  logic [3:0]            i_m0_arsize,
    input  logic [1:0]            i_m0_arburst,
    input  logic                  i_m0_arvalid,
    output logic                  o_m0_arready,
    output logic [ID_WIDTH-1:0]   o_m0_rid,
    output logic [DW-1:0]         o_m0_rdata,
    output logic [1:0]            o_m0_rresp,
    output logic                  o_m0_rlast,
    output logic                  o_m0_rvalid,
    input  logic                  i_m0_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]   i_m1_awid,
    input  logic [AW-1:0]         i_m1_awaddr,
    input  logic [7:0]            i_m1_awlen,
    input  logic [3:0]            i_m1_awsize,
    input  logic [1:0]            i_m1_awburst,
    input  logic                  i_m1_awvalid,
    output logic                  o_m1_awready,
    input  logic [DW-1:0]         i_m1_wdata,
    input  logic [DW/8-1:0]       i_m1_wstrb,
    input  logic                  i_m1_wlast,
    input  logic                  i_m1_wvalid,
    output logic                  o_m1_wready,
    output logic [ID_WIDTH-1:0]   o_m1_bid,
    output logic [1:0]            o_m1_bresp,
    output logic                  o_m1_bvalid,
    input  logic                  i_m1_bready,
    input  logic [ID_WIDTH-1:0]   i_m1_arid,
    input  logic [AW-1:0]         i_m1_araddr,
    input  logic [7:0]            i_m1_arlen,
    input  logic [3:0]            i_m1_arsize,
    input  logic [1:0]            i_m1_arburst,
    input  logic                  i_m1_arvalid,
    output logic                  o_m1_arready,
    output logic [ID_WIDTH-1:0]   o_m1_rid,
    output logic [DW-1:0]         o_m1_rdata,
    output logic [1:0]            o_m1_rresp,
    output logic                  o_m1_rlast,
    output logic                  o_m1_rvalid,
    input  logic                  i_m1_rready,
    // slave side, toward the LiteDRAM core
    output logic [ID_WIDTH:0]     o_s_awid,
    output logic [AW-1:0]         o_s_awaddr,
    output logic [7:0]            o_s_awlen,
    output logic [3:0]            o_s_awsize,
    output logic [1:0]            o_s_awburst,
    output logic                  o_s_awvalid,
    input  logic                  i_s_awready,
    output logic [DW-1:0]         o_s_wdata,
    output logic [DW/8-1:0]       o_s_wstrb,
    output logic                  o_s_wlast,
    output logic                  o_s_wvalid,
    input  logic                  i_s_wready,
    input  logic [ID_WIDTH:0]     i_s_bid,
    input  logic [1:0]            i_s_bresp,
    input  logic                  i_s_bvalid,
    output logic                  o_s_bready,
    output logic [ID_WIDTH:0]     o_s_arid,
    output logic [AW-1:0]         o_s_araddr,
    output logic [7:0]            o_s_arlen,
    output logic [3:0]            o_s_arsize,
    output logic [1:0]            o_s_arburst,
    output logic                  o_s_arvalid,
    input  logic                  i_s_arready,
    input  logic [ID_WIDTH:0]     i_s_rid,
    input  logic [DW-1:0]         i_s_rdata,
    input  logic [1:0]            i_s_rresp,
    input  logic                  i_s_rlast,
    input  logic                  i_s_rvalid,
    output logic                  o_s_rready
);

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;
    logic      w_wgnt, w_rgnt;
    logic      w_wdone, w_rdone;
    logic      w_unused_id_msb;

    // Responses route by the locked grant, so the slave ID MSB is not needed.
    assign w_unused_id_msb = i_s_bid[ID_WIDTH] ^ i_s_rid[ID_WIDTH];

    assign w_wdone = (r_wstate == W_RESP) && i_s_bvalid && o_s_bready;
    assign w_rdone = (r_rstate == R_DATA) && i_s_rvalid && o_s_rready && i_s_rlast;

    litedram_arb_rr u_wr_rr (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .i_req     ({i_m1_awvalid, i_m0_awvalid}),
        .i_load    (r_wstate == W_IDLE),
        .i_advance (w_wdone),
        .o_grant   (w_wgnt)
    );

    litedram_arb_rr u_rd_rr (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .i_req     ({i_m1_arvalid, i_m0_arvalid}),
        .i_load    (r_rstate == R_IDLE),
        .i_advance (w_rdone),
        .o_grant   (w_rgnt)
    );

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (i_m0_awvalid || i_m1_awvalid)        w_wstate_nxt = W_ADDR;
            W_ADDR:  if (i_s_awready)                         w_wstate_nxt = W_DATA;
            W_DATA:  if (o_s_wvalid && i_s_wready && o_s_wlast) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_wdone)                             w_wstate_nxt = W_IDLE;
            default:                                          w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (i_m0_arvalid || i_m1_arvalid) w_rstate_nxt = R_ADDR;
            R_ADDR:  if (i_s_arready)                  w_rstate_nxt = R_DATA;
            R_DATA:  if (w_rdone)                      w_rstate_nxt = R_IDLE;
            default:                                   w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write channel muxes: payloads are gated by state so idle outputs read 0.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        o_s_awid     = '0;
        o_s_awaddr   = '0;
        o_s_awlen    = '0;
        o_s_awsize   = '0;
        o_s_awburst  = '0;
        o_s_awvalid  = 1'b0;
        o_s_wdata    = '0;
        o_s_wstrb    = '0;
        o_s_wlast    = 1'b0;
        o_s_wvalid   = 1'b0;
        o_s_bready   = 1'b0;
        o_m0_awready = 1'b0;
        o_m1_awready = 1'b0;
        o_m0_wready  = 1'b0;
        o_m1_wready  = 1'b0;
        o_m0_bid     = '0;
        o_m1_bid     = '0;
        o_m0_bresp   = RESP_OKAY;
        o_m1_bresp   = RESP_OKAY;
        o_m0_bvalid  = 1'b0;
        o_m1_bvalid  = 1'b0;
        case (r_wstate)
            W_ADDR: begin
                o_s_awvalid  = 1'b1;
                o_s_awid     = {w_wgnt, (w_wgnt ? i_m1_awid : i_m0_awid)};
                o_s_awaddr   = w_wgnt ? i_m1_awaddr  : i_m0_awaddr;
                o_s_awlen    = w_wgnt ? i_m1_awlen   : i_m0_awlen;
                o_s_awsize   = w_wgnt ? i_m1_awsize  : i_m0_awsize;
                o_s_awburst  = w_wgnt ? i_m1_awburst : i_m0_awburst;
                o_m0_awready = !w_wgnt && i_s_awready;
                o_m1_awready =  w_wgnt && i_s_awready;
            end
            W_DATA: begin
                o_s_wvalid  = w_wgnt ? i_m1_wvalid : i_m0_wvalid;
                o_s_wdata   = w_wgnt ? i_m1_wdata  : i_m0_wdata;
                o_s_wstrb   = w_wgnt ? i_m1_wstrb  : i_m0_wstrb;
                o_s_wlast   = w_wgnt ? i_m1_wlast  : i_m0_wlast;
                o_m0_wready = !w_wgnt && i_s_wready;
                o_m1_wready =  w_wgnt && i_s_wready;
            end
            W_RESP: begin
                o_s_bready = w_wgnt ? i_m1_bready : i_m0_bready;
                if (w_wgnt) begin
                    o_m1_bvalid = i_s_bvalid;
                    o_m1_bid    = i_s_bid[ID_WIDTH-1:0];
                    o_m1_bresp  = i_s_bresp;
                end else begin
                    o_m0_bvalid = i_s_bvalid;
                    o_m0_bid    = i_s_bid[ID_WIDTH-1:0];
                    o_m0_bresp  = i_s_bresp;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_s_arid     = '0;
        o_s_araddr   = '0;
        o_s_arlen    = '0;
        o_s_arsize   = '0;
        o_s_arburst  = '0;
        o_s_arvalid  = 1'b0;
        o_s_rready   = 1'b0;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_m0_rid     = '0;
        o_m1_rid     = '0;
        o_m0_rdata   = '0;
        o_m1_rdata   = '0;
        o_m0_rresp   = RESP_OKAY;
        o_m1_rresp   = RESP_OKAY;
        o_m0_rlast   = 1'b0;
        o_m1_rlast   = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_rvalid  = 1'b0;
        case (r_rstate)
            R_ADDR: begin
                o_s_arvalid  = 1'b1;
                o_s_arid     = {w_rgnt, (w_rgnt ? i_m1_arid : i_m0_arid)};
                o_s_araddr   = w_rgnt ? i_m1_araddr  : i_m0_araddr;
                o_s_arlen    = w_rgnt ? i_m1_arlen   : i_m0_arlen;
                o_s_arsize   = w_rgnt ? i_m1_arsize  : i_m0_arsize;
                o_s_arburst  = w_rgnt ? i_m1_arburst : i_m0_arburst;
                o_m0_arready = !w_rgnt && i_s_arready;
                o_m1_arready =  w_rgnt && i_s_arready;
            end
            R_DATA: begin
                o_s_rready = w_rgnt ? i_m1_rready : i_m0_rready;
                if (w_rgnt) begin
                    o_m1_rvalid = i_s_rvalid;
                    o_m1_rid    = i_s_rid[ID_WIDTH-1:0];
                    o_m1_rdata  = i_s_rdata;
                    o_m1_rresp  = i_s_rresp;
                    o_m1_rlast  = i_s_rlast;
                end else begin
                    o_m0_rvalid = i_s_rvalid;
                    o_m0_rid    = i_s_rid[ID_WIDTH-1:0];
                    o_m0_rdata  = i_s_rdata;
                    o_m0_rresp  = i_s_rresp;
                    o_m0_rlast  = i_s_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_litedram_axi_arb.sv
// Directed bench for litedram_axi_arb: scripted masters and slave, each
// expected value written out by hand in the task arguments.
module tb_litedram_axi_arb;
    import litedram_arb_pkg::*;

    localparam int IDW = 1;

    logic user_clk;
    logic user_rst;

    logic           m_awvalid [2], m_awready [2];
    logic [IDW-1:0] m_awid    [2];
    logic [26:0]    m_awaddr  [2];
    logic [7:0]     m_awlen   [2];
    logic [3:0]     m_awsize  [2];
    logic [1:0]     m_awburst [2];
    logic [63:0]    m_wdata   [2];
    logic [7:0]     m_wstrb   [2];
    logic           m_wlast [2], m_wvalid [2], m_wready [2];
    logic [IDW-1:0] m_bid     [2];
    logic [1:0]     m_bresp   [2];
    logic           m_bvalid [2], m_bready [2];
    logic           m_arvalid [2], m_arready [2];
    logic [IDW-1:0] m_arid    [2];
    logic [26:0]    m_araddr  [2];
    logic [7:0]     m_arlen   [2];
    logic [3:0]     m_arsize  [2];
    logic [1:0]     m_arburst [2];
    logic [IDW-1:0] m_rid     [2];
    logic [63:0]    m_rdata   [2];
    logic [1:0]     m_rresp   [2];
    logic           m_rlast [2], m_rvalid [2], m_rready [2];

    logic [IDW:0] s_awid, s_bid, s_arid, s_rid;
    logic [26:0]  s_awaddr, s_araddr;
    logic [7:0]   s_awlen, s_arlen, s_wstrb;
    logic [3:0]   s_awsize, s_arsize;
    logic [1:0]   s_awburst, s_arburst, s_bresp, s_rresp;
    logic [63:0]  s_wdata, s_rdata;
    logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

    int n_total = 0;
    int n_bad   = 0;

    litedram_axi_arb #(.ID_WIDTH(IDW), .AW(27), .DW(64)) dut (
        .user_clk(user_clk), .user_rst(user_rst),
        .i_m0_awid(m_awid[0]), .i_m0_awaddr(m_awaddr[0]), .i_m0_awlen(m_awlen[0]),
        .i_m0_awsize(m_awsize[0]), .i_m0_awburst(m_awburst[0]), .i_m0_awvalid(m_awvalid[0]),
        .o_m0_awready(m_awready[0]), .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]),
        .i_m0_wlast(m_wlast[0]), .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(m_wready[0]),
        .o_m0_bid(m_bid[0]), .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]),
        .i_m0_bready(m_bready[0]), .i_m0_arid(m_arid[0]), .i_m0_araddr(m_araddr[0]),
        .i_m0_arlen(m_arlen[0]), .i_m0_arsize(m_arsize[0]), .i_m0_arburst(m_arburst[0]),
        .i_m0_arvalid(m_arvalid[0]), .o_m0_arready(m_arready[0]), .o_m0_rid(m_rid[0]),
        .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]), .o_m0_rlast(m_rlast[0]),
        .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
        .i_m1_awid(m_awid[1]), .i_m1_awaddr(m_awaddr[1]), .i_m1_awlen(m_awlen[1]),
        .i_m1_awsize(m_awsize[1]), .i_m1_awburst(m_awburst[1]), .i_m1_awvalid(m_awvalid[1]),
        .o_m1_awready(m_awready[1]), .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]),
        .i_m1_wlast(m_wlast[1]), .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(m_wready[1]),
        .o_m1_bid(m_bid[1]), .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]),
        .i_m1_bready(m_bready[1]), .i_m1_arid(m_arid[1]), .i_m1_araddr(m_araddr[1]),
        .i_m1_arlen(m_arlen[1]), .i_m1_arsize(m_arsize[1]), .i_m1_arburst(m_arburst[1]),
        .i_m1_arvalid(m_arvalid[1]), .o_m1_arready(m_arready[1]), .o_m1_rid(m_rid[1]),
        .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]), .o_m1_rlast(m_rlast[1]),
        .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
        .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
        .o_s_awburst(s_awburst), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
        .i_s_wready(s_wready), .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid),
        .o_s_bready(s_bready), .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen),
        .o_s_arsize(s_arsize), .o_s_arburst(s_arburst), .o_s_arvalid(s_arvalid),
        .i_s_arready(s_arready), .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .i_s_rlast(s_rlast), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout need=done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the edge, outputs are checked 1ns later.
    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 0; m_awid[i] = '0; m_awaddr[i] = '0; m_awlen[i] = '0;
            m_awsize[i] = '0; m_awburst[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
            m_wlast[i] = 0; m_wvalid[i] = 0; m_bready[i] = 0; m_arvalid[i] = 0;
            m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0;
            m_arburst[i] = '0; m_rready[i] = 0;
        end
        s_awready = 0; s_wready = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
        s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0;
    endtask

    task automatic reset_pulse();
        user_rst = 1;
        tick();
        user_rst = 0;
    endtask

    // One complete write burst from master m, assuming the write channel is idle.
    task automatic wr_txn(input int m, input logic [IDW-1:0] id, input logic [26:0] addr,
                          input int nb, input logic [63:0] base, input logic [1:0] resp,
                          input int aw_stall, input bit early_w);
        int o = 1 - m;
        m_awvalid[m] = 1; m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = 8'(nb - 1);
        m_awsize[m] = 4'd3; m_awburst[m] = 2'b01;
        if (early_w) begin
            m_wvalid[m] = 1; m_wdata[m] = base; m_wstrb[m] = 8'hFF; m_wlast[m] = (nb == 1);
            s_wready = 1;
        end
        settle();
        check("aw_idle_gap", s_awvalid, 0);
        if (early_w) check("w_early_idle", m_wready[m], 0);
        tick();
        for (int i = 0; i < aw_stall; i++) begin
            settle();
            check("aw_hold_valid", s_awvalid, 1);
            check("aw_hold_addr", s_awaddr, addr);
            check("aw_stall_ready", m_awready[m], 0);
            tick();
        end
        s_awready = 1;
        settle();
        check("aw_valid", s_awvalid, 1);
        check("aw_id", s_awid, {1'(m), id});
        check("aw_addr", s_awaddr, addr);
        check("aw_len", s_awlen, 8'(nb - 1));
        check("aw_ready", m_awready[m], 1);
        check("aw_other_ready", m_awready[o], 0);
        if (early_w) begin
            check("w_early_addr", m_wready[m], 0);
            check("w_early_s", s_wvalid, 0);
        end
        tick();
        m_awvalid[m] = 0; s_awready = 0;
        for (int b = 0; b < nb; b++) begin
            m_wvalid[m] = 1; m_wdata[m] = base + 64'(b); m_wstrb[m] = 8'hFF;
            m_wlast[m] = (b == nb - 1); s_wready = 1;
            settle();
            check("w_valid", s_wvalid, 1);
            check("w_data", s_wdata, base + 64'(b));
            check("w_strb", s_wstrb, 8'hFF);
            check("w_last", s_wlast, (b == nb - 1));
            check("w_ready", m_wready[m], 1);
            check("w_other_ready", m_wready[o], 0);
            tick();
        end
        m_wvalid[m] = 0; m_wlast[m] = 0; s_wready = 0;
        s_bvalid = 1; s_bid = {1'(m), id}; s_bresp = resp; m_bready[m] = 1;
        settle();
        check("w_after_last", m_wready[m], 0);
        check("b_valid", m_bvalid[m], 1);
        check("b_id", m_bid[m], id);
        check("b_resp", m_bresp[m], resp);
        check("b_other_valid", m_bvalid[o], 0);
        check("b_sready", s_bready, 1);
        tick();
        s_bvalid = 0; m_bready[m] = 0;
        settle();
        check("b_done", m_bvalid[m], 0);
    endtask

    // One read burst from master m; stops before beat abort_at if abort_at < nb.
    task automatic rd_txn(input int m, input logic [IDW-1:0] id, input logic [26:0] addr,
                          input int nb, input logic [63:0] base, input bit toggle,
                          input int abort_at);
        int o = 1 - m;
        int b = 0;
        int cyc = 0;
        m_arvalid[m] = 1; m_arid[m] = id; m_araddr[m] = addr; m_arlen[m] = 8'(nb - 1);
        m_arsize[m] = 4'd3; m_arburst[m] = 2'b01;
        settle();
        check("ar_idle_gap", s_arvalid, 0);
        tick();
        s_arready = 1;
        settle();
        check("ar_valid", s_arvalid, 1);
        check("ar_id", s_arid, {1'(m), id});
        check("ar_addr", s_araddr, addr);
        check("ar_len", s_arlen, 8'(nb - 1));
        check("ar_ready", m_arready[m], 1);
        check("ar_other_ready", m_arready[o], 0);
        tick();
        m_arvalid[m] = 0; s_arready = 0;
        while (b < nb && b != abort_at) begin
            s_rvalid = 1; s_rid = {1'(m), id}; s_rdata = base + 64'(b);
            s_rresp = RESP_OKAY; s_rlast = (b == nb - 1);
            m_rready[m] = !toggle || cyc[0];
            settle();
            check("r_valid", m_rvalid[m], 1);
            check("r_other_valid", m_rvalid[o], 0);
            check("r_sready", s_rready, m_rready[m]);
            if (m_rready[m]) begin
                check("r_data", m_rdata[m], base + 64'(b));
                check("r_id", m_rid[m], id);
                check("r_last", m_rlast[m], (b == nb - 1));
                b++;
            end
            tick();
            cyc++;
        end
        if (b == abort_at) return;
        s_rvalid = 0; s_rlast = 0; m_rready[m] = 0;
        settle();
        check("r_done", m_rvalid[m], 0);
    endtask

    initial begin
        clear_inputs();
        // Reset values, with live-looking inputs that must not leak through.
        user_rst = 1;
        m_wvalid[0] = 1; s_bvalid = 1; s_rvalid = 1; s_awready = 1; s_arready = 1;
        tick();
        tick();
        settle();
        check("rst_awvalid", s_awvalid, 0);
        check("rst_arvalid", s_arvalid, 0);
        check("rst_wvalid", s_wvalid, 0);
        check("rst_bready", s_bready, 0);
        check("rst_rready", s_rready, 0);
        check("rst_m0_bvalid", m_bvalid[0], 0);
        check("rst_m0_rvalid", m_rvalid[0], 0);
        check("rst_m0_awready", m_awready[0], 0);
        check("rst_awaddr", s_awaddr, 0);
        check("rst_awid", s_awid, 0);
        clear_inputs();
        user_rst = 0;
        tick();

        // m0 writes alone.
        wr_txn(0, 1'b1, 27'h100, 4, 64'hA0, 2'b00, 0, 0);

        // Simultaneous AW from reset: m0, then m1, then m0 again.
        reset_pulse();
        m_awvalid[1] = 1; m_awid[1] = 1'b0; m_awaddr[1] = 27'h880; m_awlen[1] = 8'd0;
        wr_txn(0, 1'b0, 27'h200, 2, 64'h10, 2'b00, 0, 0);
        m_awvalid[0] = 1;
        wr_txn(1, 1'b0, 27'h880, 1, 64'h20, 2'b01, 0, 0);
        m_awvalid[1] = 1;
        wr_txn(0, 1'b1, 27'h300, 1, 64'h30, 2'b00, 0, 0);
        m_awvalid[1] = 0;
        tick();

        // Concurrent read by m0 and write by m1.
        fork
            wr_txn(1, 1'b0, 27'h2000, 2, 64'hB0, 2'b00, 0, 0);
            rd_txn(0, 1'b1, 27'h3000, 8, 64'hC0, 0, 8);
        join
        tick();

        // Slave backpressure: AW stall, then toggling R ready.
        wr_txn(0, 1'b0, 27'h4000, 3, 64'hD0, 2'b10, 5, 0);
        rd_txn(0, 1'b0, 27'h5000, 4, 64'hE0, 1, 4);
        tick();

        // Early W from m1 must wait for its AW grant.
        wr_txn(1, 1'b1, 27'h6000, 2, 64'hF0, 2'b00, 0, 1);
        tick();

        // Reset during beat 2 of an 8-beat read (read pointer currently at m1).
        rd_txn(0, 1'b1, 27'h7000, 8, 64'h100, 0, 2);
        s_rvalid = 1; s_rid = 2'b01; s_rdata = 64'h102; s_rlast = 0; m_rready[0] = 1;
        user_rst = 1;
        settle();
        check("pre_rst_rvalid", m_rvalid[0], 1);
        tick();
        settle();
        check("mid_rst_m0_rvalid", m_rvalid[0], 0);
        check("mid_rst_rready", s_rready, 0);
        check("mid_rst_arvalid", s_arvalid, 0);
        check("mid_rst_awvalid", s_awvalid, 0);
        check("mid_rst_arready", m_arready[0], 0);
        clear_inputs();
        user_rst = 0;
        tick();
        wr_txn(1, 1'b0, 27'h8000, 1, 64'h200, 2'b00, 0, 0);
        m_arvalid[1] = 1; m_arid[1] = 1'b1; m_araddr[1] = 27'h9100; m_arlen[1] = 8'd1;
        rd_txn(0, 1'b0, 27'h9000, 2, 64'h300, 0, 2);
        rd_txn(1, 1'b1, 27'h9100, 2, 64'h400, 0, 2);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
